fifo_stream_reader: RTL and testbench

FIFO_STREAM_READER -- requirements
Module: fifo_stream_reader

---
 rtl/fifo_stream_reader.sv | 115 +++++++++++
 tb/tb_fifo_stream_reader.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_stream_reader.sv
// Adapts a one-cycle-latency synchronous FIFO read port to a valid/ready stream
// through a two-entry skid buffer. Define FIFO_RDR_COUNT_EN to add the word_count output.
module fifo_stream_reader #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_r_en,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data
`ifdef FIFO_RDR_COUNT_EN
  ,
  output logic [15:0]           word_count
`endif
);

  localparam logic [1:0] OCC_EMPTY = 2'd0;
  localparam logic [1:0] OCC_ONE   = 2'd1;
  localparam logic [1:0] OCC_TWO   = 2'd2;

  logic [1:0]            occ_q, occ_d;
  logic                  rd_pend_q, rd_pend_d;
  logic [DATA_WIDTH-1:0] head_q, head_d;
  logic [DATA_WIDTH-1:0] tail_q, tail_d;
  logic                  pop;
  logic                  capture;
  logic [2:0]            demand;

  // A read may only launch if the word it returns is guaranteed a free slot,
  // counting the word already in flight and the one leaving this cycle.
  always_comb begin
    pop       = (occ_q != OCC_EMPTY) & m_ready;
    capture   = rd_pend_q;
    demand    = {1'b0, occ_q} + {2'b00, rd_pend_q} - {2'b00, pop};
    fifo_r_en = rst_n & ~fifo_empty & (demand < 3'd2);
    rd_pend_d = fifo_r_en;
  end

  always_comb begin
    occ_d  = occ_q;
    head_d = head_q;
    tail_d = tail_q;
    case (occ_q)
      OCC_EMPTY: begin
        if (capture) begin
          head_d = fifo_data;
          occ_d  = OCC_ONE;
        end
      end
      OCC_ONE: begin
        if (capture && pop) begin
          head_d = fifo_data;
        end else if (capture) begin
          tail_d = fifo_data;
          occ_d  = OCC_TWO;
        end else if (pop) begin
          occ_d  = OCC_EMPTY;
        end
      end
      OCC_TWO: begin
        // Full buffer: the tail moves up to the head and any arriving word refills the tail.
        if (pop) begin
          head_d = tail_q;
          if (capture) begin
            tail_d = fifo_data;
          end else begin
            occ_d  = OCC_ONE;
          end
        end
      end
      default: begin
        occ_d = OCC_EMPTY;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_q     <= OCC_EMPTY;
      rd_pend_q <= 1'b0;
      head_q    <= '0;
      tail_q    <= '0;
    end else begin
      occ_q     <= occ_d;
      rd_pend_q <= rd_pend_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
    end
  end

  assign m_valid = (occ_q != OCC_EMPTY);
  assign m_data  = head_q;

`ifdef FIFO_RDR_COUNT_EN
  logic [15:0] count_q, count_d;

  always_comb begin
    count_d = pop ? count_q + 16'd1 : count_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= 16'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign word_count = count_q;
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: directed vector table, randomized traffic against an
// in-order word scoreboard, mid-operation resets and (with FIFO_RDR_COUNT_EN) counter wrap.
module tb_fifo_stream_reader;

  localparam int DW = 8;

  logic          clk;
  logic          rst_n;
  logic          fifo_empty;
  logic [DW-1:0] fifo_data;
  logic          fifo_r_en;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
`ifdef FIFO_RDR_COUNT_EN
  logic [15:0]   word_count;
`endif

  fifo_stream_reader #(.DATA_WIDTH(DW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .fifo_r_en  (fifo_r_en),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data)
`ifdef FIFO_RDR_COUNT_EN
    ,
    .word_count (word_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Upstream FIFO: every word ever written lives in mem at its write index, so
  // the scoreboard simply expects mem[pop_idx] on each accepted stream beat.
  logic [DW-1:0] mem [0:255];
  int wr_ptr;
  int rd_ptr;

  assign fifo_empty = (rd_ptr == wr_ptr);

  always @(posedge clk) begin
    if (fifo_r_en && !fifo_empty) begin
      fifo_data <= mem[rd_ptr[7:0]];
      rd_ptr    <= rd_ptr + 1;
    end
  end

  typedef struct {
    bit          ready;
    bit          exp_r_en;
    bit          exp_valid;
    bit          chk_data;
    logic [7:0]  exp_data;
  } vec_t;

  vec_t vecs [0:30];

  int            errors;
  int            checks;
  int            pop_idx;
  bit            hold_valid;
  logic [DW-1:0] hold_data;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [DW-1:0] val);
    mem[wr_ptr[7:0]] = val;
    wr_ptr++;
  endtask

  task automatic applyStimulus(input bit ready);
    m_ready = ready;
    #1;
  endtask

  // Per-cycle rules that hold everywhere: no read of an empty FIFO, no more than
  // two words between FIFO and consumer, order preserved, word held under backpressure.
  task automatic checkOutput();
    check("r_en_while_empty", 32'(fifo_r_en & fifo_empty), 32'd0);
    check("buffer_bound", 32'((rd_ptr - pop_idx) <= 2), 32'd1);
    if (hold_valid) begin
      check("hold_valid", 32'(m_valid), 32'd1);
      check("hold_data", 32'(m_data), 32'(hold_data));
    end
    if (m_valid && m_ready) begin
      check($sformatf("order_word%0d", pop_idx), 32'(m_data), 32'(mem[pop_idx[7:0]]));
      pop_idx++;
    end
    hold_valid = m_valid & ~m_ready;
    hold_data  = m_data;
  endtask

  task automatic step();
    checkOutput();
    @(negedge clk);
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b1);
      step();
    end
  endtask

  task automatic runVectors(input int first, input int last);
    for (int i = first; i <= last; i++) begin
      applyStimulus(vecs[i].ready);
      check($sformatf("vec%0d_r_en", i), 32'(fifo_r_en), 32'(vecs[i].exp_r_en));
      check($sformatf("vec%0d_valid", i), 32'(m_valid), 32'(vecs[i].exp_valid));
      if (vecs[i].chk_data) begin
        check($sformatf("vec%0d_data", i), 32'(m_data), 32'(vecs[i].exp_data));
      end
      step();
    end
  endtask

  // Asynchronous reset in the middle of a cycle; anything buffered or in flight is lost,
  // so the scoreboard resumes at the next word still sitting in the FIFO.
  task automatic midReset(input string name);
    #2;
    rst_n = 1'b0;
    #1;
    check({name, "_async_valid"}, 32'(m_valid), 32'd0);
    check({name, "_async_r_en"}, 32'(fifo_r_en), 32'd0);
    check({name, "_async_data"}, 32'(m_data), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n      = 1'b1;
    pop_idx    = rd_ptr;
    hold_valid = 1'b0;
    applyStimulus(1'b0);
    check({name, "_release_valid"}, 32'(m_valid), 32'd0);
    check({name, "_release_r_en"}, 32'(fifo_r_en), 32'(!fifo_empty));
`ifdef FIFO_RDR_COUNT_EN
    check({name, "_release_count"}, 32'(word_count), 32'd0);
`endif
    step();
  endtask

  initial begin
    int base;
    int npop;
    bit pop_now;

    // 8-word stream at full rate
    vecs[0]  = '{1, 1, 0, 0, 8'h00};
    vecs[1]  = '{1, 1, 0, 0, 8'h00};
    vecs[2]  = '{1, 1, 1, 1, 8'h11};
    vecs[3]  = '{1, 1, 1, 1, 8'h12};
    vecs[4]  = '{1, 1, 1, 1, 8'h13};
    vecs[5]  = '{1, 1, 1, 1, 8'h14};
    vecs[6]  = '{1, 1, 1, 1, 8'h15};
    vecs[7]  = '{1, 1, 1, 1, 8'h16};
    vecs[8]  = '{1, 0, 1, 1, 8'h17};
    vecs[9]  = '{1, 0, 1, 1, 8'h18};
    vecs[10] = '{1, 0, 0, 0, 8'h00};
    vecs[11] = '{1, 0, 0, 0, 8'h00};
    // three words, consumer stalled for five cycles, then released
    vecs[12] = '{0, 1, 0, 0, 8'h00};
    vecs[13] = '{0, 1, 0, 0, 8'h00};
    vecs[14] = '{0, 0, 1, 1, 8'hA5};
    vecs[15] = '{0, 0, 1, 1, 8'hA5};
    vecs[16] = '{0, 0, 1, 1, 8'hA5};
    vecs[17] = '{1, 1, 1, 1, 8'hA5};
    vecs[18] = '{1, 0, 1, 1, 8'h5A};
    vecs[19] = '{1, 0, 1, 1, 8'h3C};
    vecs[20] = '{1, 0, 0, 0, 8'h00};
    // idle with an empty FIFO
    for (int i = 21; i <= 30; i++) begin
      vecs[i] = '{bit'(i % 2), 0, 0, 0, 8'h00};
    end

    errors     = 0;
    checks     = 0;
    pop_idx    = 0;
    hold_valid = 1'b0;
    hold_data  = '0;
    rst_n      = 1'b0;
    m_ready    = 1'b0;

    push(8'h40);
    push(8'h41);
    push(8'h42);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      check($sformatf("reset%0d_r_en", i), 32'(fifo_r_en), 32'd0);
      check($sformatf("reset%0d_valid", i), 32'(m_valid), 32'd0);
      check($sformatf("reset%0d_data", i), 32'(m_data), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b1);
    check("release_first_r_en", 32'(fifo_r_en), 32'd1);
    step();
    drain(10);

    for (int i = 0; i < 8; i++) begin
      push(8'(8'h11 + i));
    end
    runVectors(0, 11);

    push(8'hA5);
    push(8'h5A);
    push(8'h3C);
    base = rd_ptr;
    runVectors(12, 16);
    check("stall_reads_issued", 32'(rd_ptr - base), 32'd2);
    runVectors(17, 20);

    runVectors(21, 30);

    for (int i = 0; i < 3000; i++) begin
      if ((wr_ptr - rd_ptr) < 8 && $urandom_range(0, 2) != 0) begin
        push(8'($urandom));
        if ($urandom_range(0, 1) != 0) push(8'($urandom));
      end
      applyStimulus($urandom_range(0, 3) != 0);
      step();
    end
    drain(12);

    // buffer full (two words held) when reset hits
    for (int i = 0; i < 5; i++) push(8'(8'hC0 + i));
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0);
      step();
    end
    midReset("rst_full");
    drain(12);

    // one word held and one read in flight when reset hits
    for (int i = 0; i < 4; i++) push(8'(8'hD0 + i));
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1);
      step();
    end
    midReset("rst_inflight");
    drain(12);

`ifdef FIFO_RDR_COUNT_EN
    #2;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n      = 1'b1;
    pop_idx    = rd_ptr;
    hold_valid = 1'b0;
    npop       = 0;
    for (int k = 0; k < 70000 && npop < 65537; k++) begin
      if ((wr_ptr - rd_ptr) < 4) begin
        for (int j = 0; j < 4; j++) push(8'(k + j));
      end
      applyStimulus(1'b1);
      pop_now = m_valid;
      checkOutput();
      if (pop_now) npop++;
      if (npop < 65537) @(negedge clk);
    end
    check("count_pop_budget", 32'(npop), 32'd65537);
    @(posedge clk);
    #1;
    m_ready = 1'b0;
    check("word_count_wrap", 32'(word_count), 32'd1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
